// File: rtl/sar_channel_scheduler_pkg.sv
// Shared definitions for the SAR channel scheduler.
//   RES_W               SAR result width
//   DEF_*               default channel count and timing
//   sched_state_e       scheduler FSM states
//   max2()              helper for sizing the shared counter
package sar_sched_pkg;
  localparam int RES_W             = 12;
  localparam int DEF_N_CH          = 4;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_CONV_CYCLES   = 13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_CAPTURE = 2'd3
  } sched_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sar_channel_scheduler_if.sv
// Result stream out of the scheduler: 1-entry valid/ready buffer with channel tag.
//   valid  buffer holds a result        (master -> slave)
//   ready  consumer accepts             (slave -> master)
//   data   converted code, RES_W bits   (master -> slave)
//   ch     channel tag, CH_W bits       (master -> slave)
interface sar_channel_scheduler_if #(parameter int CH_W = 2);
  import sar_sched_pkg::*;
  logic             valid;
  logic             ready;
  logic [RES_W-1:0] data;
  logic [CH_W-1:0]  ch;

  modport master (output valid, data, ch, input ready);
  modport slave  (input valid, data, ch, output ready);
endinterface

// File: rtl/sar_channel_scheduler_arb.sv
// Round-robin arbiter: lowest requesting index at/above the pointer wins,
// wrapping N_CH-1 -> 0. The pointer moves to adv_ch+1 when adv is strobed.
//   clk_src, reset   clock, synchronous active-high reset (pointer -> 0)
//   req              level requests
//   adv, adv_ch      advance strobe and the channel just served
//   gnt_any          some request is present
//   gnt_idx          index of the winning channel
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic            clk_src,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic            adv,
  input  logic [CH_W-1:0] adv_ch,
  output logic            gnt_any,
  output logic [CH_W-1:0] gnt_idx
);
  logic [CH_W-1:0] ptr;

  always_comb begin
    int              ci;
    logic [CH_W-1:0] c;
    gnt_any = 1'b0;
    gnt_idx = '0;
    ci      = 0;
    c       = '0;
    for (int k = 0; k < N_CH; k++) begin
      ci = (int'(ptr) + k) % N_CH;
      c  = CH_W'(ci);
      if (!gnt_any && req[c]) begin
        gnt_any = 1'b1;
        gnt_idx = c;
      end
    end
  end

  always_ff @(posedge clk_src) begin
    if (reset)
      ptr <= '0;
    else if (adv)
      ptr <= (adv_ch == CH_W'(N_CH - 1)) ? '0 : adv_ch + 1'b1;
  end
endmodule

// File: rtl/sar_channel_scheduler.sv
// Multi-channel conversion scheduler in front of a SAR core.
// Grants one requester round-robin, tracks with sample_en for SAMPLE_CYCLES,
// releases sar_rst for CONV_CYCLES, then captures the code into a 1-entry
// valid/ready buffer tagged with the channel.
//   clk_src, reset   clock, synchronous active-high reset
//   req / req_ack    per-channel level request / one-cycle "result buffered" pulse
//   ch_sel           analog mux select, held from SAMPLE through CAPTURE
//   sample_en        sample/hold track enable
//   sar_rst          SAR core reset, high = held/cleared
//   sar_result       SAR core code, sampled in CAPTURE
//   busy             not IDLE
//   out_if           result stream (master side)
module sar_channel_scheduler
  import sar_sched_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int CH_W          = $clog2(N_CH),
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int CONV_CYCLES   = DEF_CONV_CYCLES
) (
  input  logic                    clk_src,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         req_ack,
  output logic [CH_W-1:0]         ch_sel,
  output logic                    sample_en,
  output logic                    sar_rst,
  input  logic [RES_W-1:0]        sar_result,
  output logic                    busy,
  sar_channel_scheduler_if.master out_if
);
  localparam int CNT_W = $clog2(max2(SAMPLE_CYCLES, CONV_CYCLES) + 1);

  sched_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             gnt_any;
  logic [CH_W-1:0]  gnt_idx;
  logic             cap_load;
  logic             sample_en_d, sar_rst_d, busy_d;

  // Capture may complete when the buffer is empty or being drained this cycle.
  assign cap_load = (state == ST_CAPTURE) && (!out_if.valid || out_if.ready);

  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .clk_src (clk_src),
    .reset   (reset),
    .req     (req),
    .adv     (cap_load),
    .adv_ch  (ch_sel),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // State register; outputs are registered from the next state so they line
  // up exactly with the state they describe.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      state     <= ST_IDLE;
      sample_en <= 1'b0;
      sar_rst   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sample_en <= sample_en_d;
      sar_rst   <= sar_rst_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (gnt_any)     state_nxt = ST_SAMPLE;
      ST_SAMPLE:  if (cnt == '0)   state_nxt = ST_CONVERT;
      ST_CONVERT: if (cnt == '0)   state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (cap_load)    state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sample_en_d = (state_nxt == ST_SAMPLE);
    sar_rst_d   = (state_nxt != ST_CONVERT);
    busy_d      = (state_nxt != ST_IDLE);
  end

  // One down-counter times both SAMPLE and CONVERT; it is loaded with
  // length-1 on entry and the phase ends on the cycle it reads zero.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      cnt    <= '0;
      ch_sel <= '0;
    end else begin
      case (state)
        ST_IDLE: if (gnt_any) begin
          ch_sel <= gnt_idx;
          cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
        end
        ST_SAMPLE:  cnt <= (cnt == '0) ? CNT_W'(CONV_CYCLES - 1) : cnt - 1'b1;
        ST_CONVERT: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Output buffer: a capture reloads it even while the old entry is being
  // taken, so valid stays high across a simultaneous handshake + capture.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      out_if.valid <= 1'b0;
      out_if.data  <= '0;
      out_if.ch    <= '0;
      req_ack      <= '0;
    end else begin
      req_ack <= '0;
      if (cap_load) begin
        out_if.valid <= 1'b1;
        out_if.data  <= sar_result;
        out_if.ch    <= ch_sel;
        req_ack      <= N_CH'(1) << ch_sel;
      end else if (out_if.valid && out_if.ready) begin
        out_if.valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sar_channel_scheduler.sv
// Lockstep bench: a transaction-level model (elapsed cycles since grant,
// pointer, buffer) predicts every output each cycle; directed scenarios add
// latency, ordering and backpressure checks, then a random phase runs.
module tb_sar_channel_scheduler;
  import sar_sched_pkg::*;
  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int S      = 4;
  localparam int C      = 13;
  localparam int CAP_PH = S + C + 1;   // elapsed cycles at which capture happens
  localparam int PERIOD = 1 + S + C + 1;

  logic             clk_src = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  req, req_ack;
  logic [CH_W-1:0]  ch_sel;
  logic             sample_en, sar_rst, busy;
  logic [RES_W-1:0] sar_result;

  sar_channel_scheduler_if #(.CH_W(CH_W)) out_if ();

  sar_channel_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .SAMPLE_CYCLES(S), .CONV_CYCLES(C)) dut (
    .clk_src    (clk_src),
    .reset      (reset),
    .req        (req),
    .req_ack    (req_ack),
    .ch_sel     (ch_sel),
    .sample_en  (sample_en),
    .sar_rst    (sar_rst),
    .sar_result (sar_result),
    .busy       (busy),
    .out_if     (out_if)
  );

  always #5 clk_src = ~clk_src;

  int n_chk = 0, n_bad = 0, cyc = 0;

  // model: m_ph = cycles since grant (0 = idle), stalls at CAP_PH
  int               m_ph = 0, m_ch = 0, m_ptr = 0, m_bc = 0;
  bit               m_bv = 0;
  logic [RES_W-1:0] m_bd = '0;
  logic [N_CH-1:0]  m_ack = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit              load;
    logic [N_CH-1:0] ack_n;
    if (reset) begin
      m_ph = 0; m_ch = 0; m_ptr = 0; m_bv = 0; m_bd = '0; m_bc = 0; m_ack = '0;
      return;
    end
    load  = 0;
    ack_n = '0;
    if (m_ph == 0) begin
      if (req != '0) begin
        for (int k = 0; k < N_CH; k++)
          if (req[(m_ptr + k) % N_CH]) begin m_ch = (m_ptr + k) % N_CH; break; end
        m_ph = 1;
      end
    end else if (m_ph < CAP_PH) begin
      m_ph++;
    end else if (!m_bv || out_if.ready) begin
      load = 1; m_bd = sar_result; m_bc = m_ch; ack_n[m_ch] = 1'b1;
      m_ptr = (m_ch + 1) % N_CH; m_ph = 0;
    end
    if (load) m_bv = 1;
    else if (m_bv && out_if.ready) m_bv = 0;
    m_ack = ack_n;
  endtask

  task automatic compare_all();
    chk("busy",      busy,         m_ph != 0);
    chk("sample_en", sample_en,    (m_ph >= 1) && (m_ph <= S));
    chk("sar_rst",   sar_rst,      !((m_ph > S) && (m_ph <= S + C)));
    chk("ch_sel",    ch_sel,       m_ch);
    chk("req_ack",   req_ack,      m_ack);
    chk("out_valid", out_if.valid, m_bv);
    chk("out_data",  out_if.data,  m_bd);
    chk("out_ch",    out_if.ch,    m_bc);
  endtask

  task automatic tick();
    @(posedge clk_src);
    model_step();
    cyc++;
    @(negedge clk_src);
    compare_all();
    sar_result = RES_W'($urandom);
  endtask

  // Advance until the buffer shows valid; a timeout counts as a failure.
  task automatic wait_out(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_if.valid === 1'b1) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    int t0, prev, se_n, rl_n, ack_n, rst_lo;
    logic [RES_W-1:0] keep;
    reset = 1'b1; req = '0; out_if.ready = 1'b0; sar_result = RES_W'($urandom);
    tick(); tick();
    chk("rst_sar_rst", sar_rst, 1);
    chk("rst_valid",   out_if.valid, 0);
    reset = 1'b0;
    tick();

    // 1: single conversion on ch2
    out_if.ready = 1'b1; req = 4'b0100; t0 = cyc; se_n = 0; rl_n = 0; ack_n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      se_n  += int'(sample_en);
      rl_n  += int'(!sar_rst);
      ack_n += int'(req_ack[2]);
      if (out_if.valid === 1'b1) break;
    end
    chk("s1_latency", cyc - t0, 19);
    chk("s1_sample_cycles", se_n, S);
    chk("s1_conv_cycles", rl_n, C);
    chk("s1_ack", ack_n, 1);
    chk("s1_ch", out_if.ch, 2);
    req = '0;
    tick();

    // 4: pointer is now 3; ch3 then ch0
    req = 4'b1001;
    wait_out("s4_wait1"); chk("s4_first", out_if.ch, 3);
    wait_out("s4_wait2"); chk("s4_second", out_if.ch, 0);
    req = '0;
    tick();

    // 2: round-robin from pointer 0, all requesting
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_out("s2_wait");
      chk("s2_ch", out_if.ch, k % N_CH);
      if (k > 0) chk("s2_gap", cyc - prev, PERIOD);
      prev = cyc;
    end
    req = '0;
    tick();

    // 3: backpressure, pointer is 1 -> ch1 then ch0 stalls in capture
    out_if.ready = 1'b0; req = 4'b0011;
    wait_out("s3_wait");
    chk("s3_first_ch", out_if.ch, 1);
    keep = out_if.data; req = 4'b0001;
    repeat (40) tick();
    chk("s3_hold_data", out_if.data, keep);
    chk("s3_hold_ch", out_if.ch, 1);
    chk("s3_stall_sar_rst", sar_rst, 1);
    chk("s3_stall_busy", busy, 1);
    out_if.ready = 1'b1; req = '0;
    tick();
    chk("s3_reload_valid", out_if.valid, 1);
    chk("s3_reload_ch", out_if.ch, 0);
    tick();
    chk("s3_drained", out_if.valid, 0);

    // 6: request dropped during SAMPLE, pointer is 1
    req = 4'b0100;
    repeat (3) tick();
    req = '0;
    wait_out("s6_wait");
    chk("s6_ch", out_if.ch, 2);
    chk("s6_ack", req_ack, 4'b0100);
    req = 4'b1111;
    wait_out("s6_wait2");
    chk("s6_next_ch", out_if.ch, 3);
    req = '0; out_if.ready = 1'b0;   // leave the ch3 entry pending

    // 5: reset on the 8th CONVERT cycle discards everything
    req = 4'b0001; rst_lo = 0;
    for (int i = 0; i < 100 && rst_lo < 8; i++) begin
      tick();
      rst_lo += int'(!sar_rst);
    end
    chk("s5_reached", rst_lo, 8);
    reset = 1'b1; tick();
    chk("s5_valid", out_if.valid, 0);
    chk("s5_busy", busy, 0);
    chk("s5_sar_rst", sar_rst, 1);
    chk("s5_ch_sel", ch_sel, 0);
    reset = 1'b0; out_if.ready = 1'b1;
    wait_out("s5_wait");
    chk("s5_restart_ch", out_if.ch, 0);
    req = '0;

    // random phase
    for (int i = 0; i < 2500; i++) begin
      req          = N_CH'($urandom);
      out_if.ready = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
